axis_framebuffer_reader: RTL and testbench
==========================================

# axis_framebuffer_reader

Fetches a linear 16-bit-per-pixel framebuffer from memory over an AXI4 read master and streams it out as an AXI-Stream for the display path. It is the read-side counterpart of the framebuffer writer and sits between the memory interconnect and the display controller. Read bursts are credit-limited against an internal FIFO, so the AXI R channel is never back-pressured by the display.

## Interface
- DATA_WIDTH, 32: AXI/AXIS data width in bits; a multiple of 16.
- ADDR_WIDTH, 32: AXI address width.
- STRB_WIDTH, 4: DATA_WIDTH/8.
- ID_WIDTH, 8: AXI ID width.
- FIFO_DEPTH_LG, 5: log2 of FIFO depth in beats; minimum 4.
- Fixed constants (not parameters): FB_SIZE_IN_PIXEL_LG = 20, PIXEL_SIZE = 16, BURST_BEATS = 16.
- aclk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  pulse that requests one frame read.
- fb_addr  in  ADDR_WIDTH  frame base address; aligned to BURST_BEATS*STRB_WIDTH bytes.
- fb_size  in  20  frame size in pixels.
- idle  out  1  high when no frame is in progress.
- m_mem_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  AXI4 read address channel.
- m_mem_axi_arvalid  out  1; m_mem_axi_arready  in  1.
- m_mem_axi_rid  in  ID_WIDTH; m_mem_axi_rdata  in  DATA_WIDTH; m_mem_axi_rresp  in  2; m_mem_axi_rlast  in  1; m_mem_axi_rvalid  in  1; m_mem_axi_rready  out  1.
- m_disp_axis_tvalid  out  1; m_disp_axis_tready  in  1; m_disp_axis_tlast  out  1; m_disp_axis_tdata  out  DATA_WIDTH; m_disp_axis_tstrb  out  STRB_WIDTH.

## Operation
- PPB = DATA_WIDTH/16 pixels per beat. BEATS = ceil(fb_size/PPB). Burst k has address fb_addr + k*16*STRB_WIDTH. Every burst uses arlen 15 except the final one, which uses arlen = (BEATS-1) mod 16.
- Constant AR fields: arid 0, arsize log2(STRB_WIDTH), arburst 2'b01 (INCR), arlock 0, arcache 4'b0000, arprot 3'b000.
- States:
  - IDLE: start && fb_size != 0 latches fb_addr and BEATS, then goes to ACTIVE.
  - ACTIVE: returns to IDLE after the AXIS handshake on the beat with tlast set.
- In IDLE, start with fb_size == 0 is ignored. In ACTIVE, start is ignored.
- Credit: credit = 2^FIFO_DEPTH_LG − fifo_count − outstanding.
  - outstanding increases by arlen+1 on an AR handshake and decreases by 1 on each R handshake.
  - arvalid is asserted only while bursts remain and credit ≥ the next burst's length.
  - arvalid, once high, stays high with stable fields until arready.
- m_mem_axi_rready = 1 in ACTIVE, 0 in IDLE. Each R beat is pushed to the FIFO.
- rresp, rid and rlast are ignored; data is forwarded regardless.
- FIFO pop occurs on the AXIS handshake. tdata is FIFO data in order.
- tstrb is all ones, except on the last beat when fb_size mod PPB != 0: only the low (fb_size mod PPB)*2 bytes are set.
- tlast is set on the beat numbered BEATS only.
- Arithmetic: beat and burst counters are 20 bits wide. BEATS ≤ 2^20; no overflow.

## Timing
- Reset values: idle 1; arvalid 0; rready 0; tvalid 0; tlast 0; all other outputs 0.
- start accepted at edge N → idle 0 and arvalid 1 at N+1.
- R handshake at edge N → the beat is visible on tvalid/tdata at N+1 at the earliest (registered FIFO output).
- Sustained throughput is 1 beat/cycle when arready, rvalid and tready are continuously high.
- tvalid, once high, holds with stable tdata/tstrb/tlast until tready.
- Final tlast handshake at edge N → idle 1 and tvalid 0 at N+1. A start at N+1 is accepted.
- Simultaneous FIFO push and pop in one cycle: fifo_count is unchanged. A full FIFO never occurs with an R beat pending; the credit rule guarantees this.
- Reset mid-frame: all state clears at the next edge. The system resets the memory side together with this block.

## Test plan
- Basic frame: DATA_WIDTH 32, fb_addr 0x1000, fb_size 64, all ready signals high → two ARs at 0x1000 and 0x1040, both arlen 15; 32 AXIS beats of memory data in order; tlast only on beat 32; idle 1 one cycle later.
- Partial frame: fb_size 37 → BEATS 19; ARs are arlen 15 @base and arlen 2 @base+0x40; last beat has tstrb 4'b0011 and tlast.
- Backpressure: FIFO_DEPTH_LG 5, tready held 0 → at most 2 ARs issued, rready stays 1, no beat lost. Release tready → all 32 beats arrive in order.
- Ignored starts: start during ACTIVE → no extra AR, frame unaffected. start with fb_size 0 → no AR, idle stays 1.
- Stalls: arready delayed 5 cycles → araddr/arlen stable until handshake. Random rvalid gaps and random tready → output data sequence matches the memory image.
- Reset mid-frame: resetn low after 10 beats → idle 1 and arvalid/rready/tvalid 0 next cycle. A new start then reads the frame from the beginning.

Source files
------------

// File: rtl/axis_framebuffer_reader_if.sv
// rtl/axis_framebuffer_reader_if.sv - AXI4 read master and display AXI-Stream bundle for the framebuffer reader
interface axis_framebuffer_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   m_mem_axi_arid;
    logic [ADDR_WIDTH-1:0] m_mem_axi_araddr;
    logic [7:0]            m_mem_axi_arlen;
    logic [2:0]            m_mem_axi_arsize;
    logic [1:0]            m_mem_axi_arburst;
    logic                  m_mem_axi_arlock;
    logic [3:0]            m_mem_axi_arcache;
    logic [2:0]            m_mem_axi_arprot;
    logic                  m_mem_axi_arvalid;
    logic                  m_mem_axi_arready;
    logic [ID_WIDTH-1:0]   m_mem_axi_rid;
    logic [DATA_WIDTH-1:0] m_mem_axi_rdata;
    logic [1:0]            m_mem_axi_rresp;
    logic                  m_mem_axi_rlast;
    logic                  m_mem_axi_rvalid;
    logic                  m_mem_axi_rready;
    logic                  m_disp_axis_tvalid;
    logic                  m_disp_axis_tready;
    logic                  m_disp_axis_tlast;
    logic [DATA_WIDTH-1:0] m_disp_axis_tdata;
    logic [STRB_WIDTH-1:0] m_disp_axis_tstrb;

    modport master (
        output m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize,
               m_mem_axi_arburst, m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot,
               m_mem_axi_arvalid, m_mem_axi_rready,
               m_disp_axis_tvalid, m_disp_axis_tlast, m_disp_axis_tdata, m_disp_axis_tstrb,
        input  m_mem_axi_arready, m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp,
               m_mem_axi_rlast, m_mem_axi_rvalid, m_disp_axis_tready
    );

    modport slave (
        input  m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize,
               m_mem_axi_arburst, m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot,
               m_mem_axi_arvalid, m_mem_axi_rready,
               m_disp_axis_tvalid, m_disp_axis_tlast, m_disp_axis_tdata, m_disp_axis_tstrb,
        output m_mem_axi_arready, m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp,
               m_mem_axi_rlast, m_mem_axi_rvalid, m_disp_axis_tready
    );
endinterface

// File: rtl/axis_framebuffer_reader.sv
// rtl/axis_framebuffer_reader.sv - credit-limited AXI4 burst reader streaming a 16bpp framebuffer to AXI-Stream
module axis_framebuffer_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int STRB_WIDTH    = 4,
    parameter int ID_WIDTH      = 8,
    parameter int FIFO_DEPTH_LG = 5
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] fb_addr,
    input  logic [19:0]           fb_size,
    output logic                  idle,
    axis_framebuffer_reader_if.master bus
);
    localparam int PPB         = DATA_WIDTH / 16;
    localparam int FIFO_D      = 1 << FIFO_DEPTH_LG;
    localparam int CW          = FIFO_DEPTH_LG + 1;
    localparam int CRW         = CW + 1;
    localparam int BURST_BYTES = 16 * STRB_WIDTH;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]    r_araddr;
    logic [7:0]               r_arlen;
    logic                     r_arvalid;
    logic [19:0]              r_req_left;
    logic [19:0]              r_ld_left;
    logic [STRB_WIDTH-1:0]    r_last_strb;
    logic [CW-1:0]            r_outstanding;
    logic [CW-1:0]            r_mcnt;
    logic [FIFO_DEPTH_LG-1:0] r_wr, r_rd;
    logic [DATA_WIDTH-1:0]    r_mem [FIFO_D];
    logic [DATA_WIDTH-1:0]    r_tdata;
    logic [STRB_WIDTH-1:0]    r_tstrb;
    logic                     r_tvalid, r_tlast;

    logic [20:0]           w_sum;
    logic [19:0]           w_beats, w_rem;
    logic [STRB_WIDTH-1:0] w_last_strb;
    logic [4:0]            w_next_len;
    logic [CRW-1:0]        w_credit;
    logic w_start_ok, w_ar_hs, w_push, w_pop, w_done, w_load, w_mem_rd, w_bypass, w_mem_wr;
    logic w_unused;

    assign w_sum   = {1'b0, fb_size} + 21'(PPB - 1);
    assign w_beats = 20'(w_sum / 21'(PPB));
    assign w_rem   = fb_size % 20'(PPB);

    // Partial last beat keeps only the bytes of the pixels that exist.
    always_comb begin
        w_last_strb = '0;
        for (int i = 0; i < STRB_WIDTH; i++)
            w_last_strb[i] = (w_rem == 20'd0) || (20'(i) < {w_rem[18:0], 1'b0});
    end

    assign w_start_ok = (r_state == S_IDLE) && start && (fb_size != 20'd0);
    assign w_ar_hs    = r_arvalid && bus.m_mem_axi_arready;
    assign w_push     = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready;
    assign w_pop      = r_tvalid && bus.m_disp_axis_tready;
    assign w_done     = w_pop && r_tlast;
    assign w_next_len = (r_req_left >= 20'd16) ? 5'd16 : 5'(r_req_left);
    // Output register counts as FIFO occupancy so total buffering never exceeds the depth.
    assign w_credit   = CRW'(FIFO_D) - CRW'(r_mcnt) - CRW'(r_tvalid) - CRW'(r_outstanding);

    // The output register refills from storage first, otherwise straight from the R channel.
    assign w_load   = !r_tvalid || w_pop;
    assign w_mem_rd = w_load && (r_mcnt != '0);
    assign w_bypass = w_load && (r_mcnt == '0) && w_push;
    assign w_mem_wr = w_push && !w_bypass;

    assign w_unused = &{1'b0, bus.m_mem_axi_rid, bus.m_mem_axi_rresp, bus.m_mem_axi_rlast};

    always_ff @(posedge aclk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_done)     w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (w_mem_wr) r_mem[r_wr] <= bus.m_mem_axi_rdata;
    end

    always_ff @(posedge aclk) begin
        if (!resetn || w_done) begin
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arvalid     <= 1'b0;
            r_req_left    <= '0;
            r_ld_left     <= '0;
            r_last_strb   <= '0;
            r_outstanding <= '0;
            r_mcnt        <= '0;
            r_wr          <= '0;
            r_rd          <= '0;
            r_tdata       <= '0;
            r_tstrb       <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
        end else if (w_start_ok) begin
            r_araddr    <= fb_addr;
            r_arlen     <= (w_beats >= 20'd16) ? 8'd15 : 8'(w_beats - 20'd1);
            r_arvalid   <= 1'b1;
            r_req_left  <= w_beats;
            r_ld_left   <= w_beats;
            r_last_strb <= w_last_strb;
        end else if (r_state == S_ACTIVE) begin
            if (w_ar_hs) begin
                r_arvalid  <= 1'b0;
                r_araddr   <= r_araddr + ADDR_WIDTH'(BURST_BYTES);
                r_req_left <= r_req_left - 20'(r_arlen) - 20'd1;
            end else if (!r_arvalid && (r_req_left != 20'd0) && (w_credit >= CRW'(w_next_len))) begin
                r_arvalid <= 1'b1;
                r_arlen   <= 8'(w_next_len - 5'd1);
            end
            r_outstanding <= r_outstanding + (w_ar_hs ? CW'(r_arlen) + CW'(1) : CW'(0))
                                           - (w_push ? CW'(1) : CW'(0));
            if (w_mem_wr) r_wr <= r_wr + 1'b1;
            if (w_mem_rd) r_rd <= r_rd + 1'b1;
            r_mcnt <= r_mcnt + CW'(w_mem_wr) - CW'(w_mem_rd);
            if (w_load) begin
                if (w_mem_rd || w_bypass) begin
                    r_tdata   <= w_mem_rd ? r_mem[r_rd] : bus.m_mem_axi_rdata;
                    r_tvalid  <= 1'b1;
                    r_tlast   <= (r_ld_left == 20'd1);
                    r_tstrb   <= (r_ld_left == 20'd1) ? r_last_strb : '1;
                    r_ld_left <= r_ld_left - 20'd1;
                end else begin
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            end
        end
    end

    assign idle                   = (r_state == S_IDLE);
    assign bus.m_mem_axi_arid     = ID_WIDTH'(0);
    assign bus.m_mem_axi_araddr   = r_araddr;
    assign bus.m_mem_axi_arlen    = r_arlen;
    assign bus.m_mem_axi_arsize   = r_arvalid ? 3'($clog2(STRB_WIDTH)) : 3'd0;
    assign bus.m_mem_axi_arburst  = r_arvalid ? 2'b01 : 2'b00;
    assign bus.m_mem_axi_arlock   = 1'b0;
    assign bus.m_mem_axi_arcache  = 4'b0000;
    assign bus.m_mem_axi_arprot   = 3'b000;
    assign bus.m_mem_axi_arvalid  = r_arvalid;
    assign bus.m_mem_axi_rready   = (r_state == S_ACTIVE);
    assign bus.m_disp_axis_tvalid = r_tvalid;
    assign bus.m_disp_axis_tlast  = r_tlast;
    assign bus.m_disp_axis_tdata  = r_tdata;
    assign bus.m_disp_axis_tstrb  = r_tstrb;
endmodule

// File: tb/tb_axis_framebuffer_reader.sv
// tb/tb_axis_framebuffer_reader.sv - self-checking bench for axis_framebuffer_reader
module tb_axis_framebuffer_reader;
    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fb_addr = '0;
    logic [19:0] fb_size = '0;
    logic        idle;

    axis_framebuffer_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8)) bus ();

    axis_framebuffer_reader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8), .FIFO_DEPTH_LG(5)
    ) dut (
        .aclk(aclk), .resetn(resetn), .start(start), .fb_addr(fb_addr),
        .fb_size(fb_size), .idle(idle), .bus(bus)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } bt_t;
    ar_t exp_ar[$];
    bt_t exp_bt[$];
    logic [31:0] rq[$];

    int n_checks = 0;
    int n_fail = 0;
    int ar_count = 0;
    int beats_popped = 0;
    int tready_mode = 1;
    int ar_delay = 0;
    bit r_gaps = 0;
    bit done_pending = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected AR list and beat list from frame geometry alone.
    task automatic build_model(input logic [31:0] base, input int size);
        int beats, nb;
        ar_t a;
        bt_t b;
        exp_ar.delete();
        exp_bt.delete();
        beats = (size + 1) / 2;
        nb = (beats + 15) / 16;
        for (int k = 0; k < nb; k++) begin
            a.addr = base + 32'(k * 64);
            a.len  = (k == nb - 1) ? 8'((beats - 1) % 16) : 8'd15;
            exp_ar.push_back(a);
        end
        for (int i = 0; i < beats; i++) begin
            b.data = memword(base + 32'(4 * i));
            b.strb = (i == beats - 1 && (size % 2) == 1) ? 4'b0011 : 4'b1111;
            b.last = (i == beats - 1);
            exp_bt.push_back(b);
        end
    endtask

    // Memory slave and display sink; inputs change 1 time unit after the rising edge.
    initial begin : drv
        bit s_rst, s_ar, s_r;
        logic [31:0] s_addr;
        logic [7:0] s_len;
        int ar_wait;
        ar_wait = 0;
        bus.m_mem_axi_arready = 1'b0; bus.m_mem_axi_rvalid = 1'b0; bus.m_mem_axi_rdata = '0;
        bus.m_mem_axi_rid = '0; bus.m_mem_axi_rresp = '0; bus.m_mem_axi_rlast = 1'b0;
        bus.m_disp_axis_tready = 1'b0;
        forever begin
            @(negedge aclk);
            s_rst  = !resetn;
            s_ar   = bus.m_mem_axi_arvalid && bus.m_mem_axi_arready;
            s_r    = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready;
            s_addr = bus.m_mem_axi_araddr;
            s_len  = bus.m_mem_axi_arlen;
            @(posedge aclk);
            #1;
            if (s_rst) begin
                rq.delete();
                bus.m_mem_axi_rvalid = 1'b0;
                bus.m_mem_axi_arready = 1'b0;
                ar_wait = 0;
            end else begin
                if (s_ar) begin
                    for (int j = 0; j <= int'(s_len); j++) rq.push_back(s_addr + 32'(4 * j));
                    ar_wait = 0;
                end
                if (s_r) void'(rq.pop_front());
                if (!bus.m_mem_axi_rvalid || s_r) begin
                    if (rq.size() != 0 && (!r_gaps || $urandom_range(0, 2) != 0)) begin
                        bus.m_mem_axi_rvalid = 1'b1;
                        bus.m_mem_axi_rdata  = memword(rq[0]);
                        bus.m_mem_axi_rid    = 8'($urandom);
                        bus.m_mem_axi_rresp  = 2'($urandom);
                        bus.m_mem_axi_rlast  = 1'($urandom);
                    end else begin
                        bus.m_mem_axi_rvalid = 1'b0;
                    end
                end
                if (ar_delay == 0) bus.m_mem_axi_arready = 1'b1;
                else if (s_ar || !bus.m_mem_axi_arvalid) bus.m_mem_axi_arready = 1'b0;
                else if (ar_wait >= ar_delay) bus.m_mem_axi_arready = 1'b1;
                else ar_wait++;
            end
            case (tready_mode)
                0: bus.m_disp_axis_tready = 1'b0;
                1: bus.m_disp_axis_tready = 1'b1;
                default: bus.m_disp_axis_tready = 1'($urandom);
            endcase
        end
    end

    // Compare process: every cycle, DUT outputs against the model heads.
    initial begin : cmp
        forever begin
            @(negedge aclk);
            if (!resetn) begin
                done_pending = 0;
                continue;
            end
            if (done_pending) begin
                check("idle_after_last", 64'(idle), 64'(1));
                check("tvalid_after_last", 64'(bus.m_disp_axis_tvalid), 64'(0));
                done_pending = 0;
            end
            check("rready_vs_active", 64'(bus.m_mem_axi_rready), 64'(!idle));
            if (bus.m_mem_axi_arvalid) begin
                check("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
                if (exp_ar.size() != 0) begin
                    check("araddr", 64'(bus.m_mem_axi_araddr), 64'(exp_ar[0].addr));
                    check("arlen", 64'(bus.m_mem_axi_arlen), 64'(exp_ar[0].len));
                    check("arsize", 64'(bus.m_mem_axi_arsize), 64'(2));
                    check("arburst", 64'(bus.m_mem_axi_arburst), 64'(1));
                    if (bus.m_mem_axi_arready) begin
                        void'(exp_ar.pop_front());
                        ar_count++;
                    end
                end
            end
            if (bus.m_disp_axis_tvalid) begin
                check("beat_expected", 64'(exp_bt.size() != 0), 64'(1));
                if (exp_bt.size() != 0) begin
                    check("tdata", 64'(bus.m_disp_axis_tdata), 64'(exp_bt[0].data));
                    check("tstrb", 64'(bus.m_disp_axis_tstrb), 64'(exp_bt[0].strb));
                    check("tlast", 64'(bus.m_disp_axis_tlast), 64'(exp_bt[0].last));
                    if (bus.m_disp_axis_tready) begin
                        void'(exp_bt.pop_front());
                        beats_popped++;
                        if (bus.m_disp_axis_tlast) done_pending = 1;
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] a, input logic [19:0] s);
        @(posedge aclk);
        #1;
        fb_addr = a;
        fb_size = s;
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] a, input int s);
        build_model(a, s);
        ar_count = 0;
        beats_popped = 0;
        pulse_start(a, 20'(s));
        check("idle_after_start", 64'(idle), 64'(0));
        check("arvalid_after_start", 64'(bus.m_mem_axi_arvalid), 64'(1));
    endtask

    task automatic wait_frame(input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound && !(idle && exp_bt.size() == 0)) begin
            @(posedge aclk);
            #1;
            cycles++;
        end
        check("frame_complete", 64'(idle), 64'(1));
        check("beats_left", 64'(exp_bt.size()), 64'(0));
        check("ars_left", 64'(exp_ar.size()), 64'(0));
    endtask

    initial begin : main
        int cyc;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_arvalid", 64'(bus.m_mem_axi_arvalid), 64'(0));
        check("rst_rready", 64'(bus.m_mem_axi_rready), 64'(0));
        check("rst_tvalid", 64'(bus.m_disp_axis_tvalid), 64'(0));
        check("rst_tlast", 64'(bus.m_disp_axis_tlast), 64'(0));
        check("rst_araddr", 64'(bus.m_mem_axi_araddr), 64'(0));
        check("rst_tdata", 64'(bus.m_disp_axis_tdata), 64'(0));
        resetn = 1'b1;

        // Basic frame at full throughput.
        build_model(32'h1000, 64);
        check("model_ar0_addr", 64'(exp_ar[0].addr), 64'h1000);
        check("model_ar1_addr", 64'(exp_ar[1].addr), 64'h1040);
        check("model_ar1_len", 64'(exp_ar[1].len), 64'd15);
        check("model_beats64", 64'(exp_bt.size()), 64'd32);
        start_frame(32'h1000, 64);
        wait_frame(200, cyc);
        check("basic_throughput", 64'(cyc <= 40), 64'(1));
        check("basic_ar_count", 64'(ar_count), 64'd2);
        check("basic_beats", 64'(beats_popped), 64'd32);

        // Partial last beat and single-pixel frame.
        build_model(32'h2000, 37);
        check("model_beats37", 64'(exp_bt.size()), 64'd19);
        check("model_ar1_len37", 64'(exp_ar[1].len), 64'd2);
        check("model_ar1_addr37", 64'(exp_ar[1].addr), 64'h2040);
        check("model_last_strb37", 64'(exp_bt[18].strb), 64'b0011);
        start_frame(32'h2000, 37);
        wait_frame(200, cyc);
        start_frame(32'h2400, 1);
        wait_frame(100, cyc);

        // Display backpressure: credit caps requests at the FIFO depth.
        tready_mode = 0;
        start_frame(32'h3000, 128);
        repeat (100) @(posedge aclk);
        #1;
        check("bp_ar_count", 64'(ar_count), 64'd2);
        check("bp_rready", 64'(bus.m_mem_axi_rready), 64'(1));
        check("bp_tvalid", 64'(bus.m_disp_axis_tvalid), 64'(1));
        tready_mode = 1;
        wait_frame(400, cyc);
        check("bp_beats", 64'(beats_popped), 64'd64);

        // Ignored starts.
        start_frame(32'h4000, 64);
        repeat (5) @(posedge aclk);
        pulse_start(32'h9000, 20'd10);
        wait_frame(300, cyc);
        check("ignored_ar_count", 64'(ar_count), 64'd2);
        pulse_start(32'h9000, 20'd0);
        repeat (5) begin
            check("size0_idle", 64'(idle), 64'(1));
            check("size0_arvalid", 64'(bus.m_mem_axi_arvalid), 64'(0));
            @(posedge aclk);
            #1;
        end

        // AR stalls, R gaps, random display readiness.
        ar_delay = 5;
        r_gaps = 1;
        tready_mode = 2;
        start_frame(32'h5000, 200);
        wait_frame(3000, cyc);
        check("stall_ar_count", 64'(ar_count), 64'd7);
        check("stall_beats", 64'(beats_popped), 64'd100);

        // Reset mid-frame, then a full frame from the beginning.
        ar_delay = 0;
        start_frame(32'h6000, 64);
        cyc = 0;
        while (beats_popped < 10 && cyc < 500) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        check("mid_beats_reached", 64'(beats_popped >= 10), 64'(1));
        resetn = 1'b0;
        @(posedge aclk);
        #1;
        check("midrst_idle", 64'(idle), 64'(1));
        check("midrst_arvalid", 64'(bus.m_mem_axi_arvalid), 64'(0));
        check("midrst_rready", 64'(bus.m_mem_axi_rready), 64'(0));
        check("midrst_tvalid", 64'(bus.m_disp_axis_tvalid), 64'(0));
        exp_ar.delete();
        exp_bt.delete();
        resetn = 1'b1;
        repeat (2) @(posedge aclk);
        start_frame(32'h6000, 64);
        wait_frame(1000, cyc);
        check("post_rst_beats", 64'(beats_popped), 64'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
